// File: rtl/sumador8_ctrl.sv
// sumador8_ctrl: round-robin sequencer for two 8-bit add/subtract clients
// sharing one registered 4-bit adder (sumador4). Each operation runs as a
// low-nibble pass followed by a high-nibble pass with carry/borrow chained
// through ADD_RCI, and completes with a one-cycle ACK to the granted client.
//
// Build option: define SUMADOR8_CLR_EN to clear the adder (MODO=11) during
// DONE; when undefined the adder is left holding the last high nibble/carry.
module sumador8_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       OP0,
    input  logic       OP1,
    input  logic [7:0] A0,
    input  logic [7:0] B0,
    input  logic [7:0] A1,
    input  logic [7:0] B1,
    output logic       ACK0,
    output logic       ACK1,
    output logic [7:0] RES,
    output logic       CO,
    output logic       BUSY,
    output logic       ADD_ENB,
    output logic [1:0] ADD_MODO,
    output logic [3:0] ADD_A,
    output logic [3:0] ADD_B,
    output logic       ADD_RCI,
    input  logic [3:0] ADD_Q,
    input  logic       ADD_RCO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [1:0] MODO_HOLD = 2'b00;
    localparam logic [1:0] MODO_ADD  = 2'b01;
    localparam logic [1:0] MODO_SUB  = 2'b10;
    localparam logic [1:0] MODO_CLR  = 2'b11;

    state_t     r_state;
    state_t     w_next;

    logic       r_last;
    logic       r_gnt;
    logic       r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_lo;
    logic [7:0] r_res;
    logic       r_co;
    logic       r_ack0;
    logic       r_ack1;

    logic       w_elig0;
    logic       w_elig1;
    logic       w_grant;
    logic       w_gnt_idx;
    logic       w_enb;
    logic [1:0] w_modo;
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic       w_rci;

    // Adder mode for the latched operation
    function automatic logic [1:0] f_mode(input logic op);
        return op ? MODO_SUB : MODO_ADD;
    endfunction

    // Arbitration: a client that is being acknowledged this cycle sits out,
    // and on a tie the client that was not served last wins
    always_comb begin
        w_elig0   = REQ0 && !r_ack0;
        w_elig1   = REQ1 && !r_ack1;
        w_grant   = (r_state == S_IDLE) && (w_elig0 || w_elig1);
        w_gnt_idx = (w_elig0 && w_elig1) ? ~r_last : w_elig1;
    end

    // Next-state and adder-drive decode
    always_comb begin
        w_next = r_state;
        w_enb  = 1'b0;
        w_modo = MODO_HOLD;
        w_a    = 4'd0;
        w_b    = 4'd0;
        w_rci  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = S_LO;
                end
            end
            S_LO: begin
                w_enb  = 1'b1;
                w_modo = f_mode(r_op);
                w_a    = r_a[3:0];
                w_b    = r_b[3:0];
                w_next = S_HI;
            end
            S_HI: begin
                w_enb  = 1'b1;
                w_modo = f_mode(r_op);
                w_a    = r_a[7:4];
                w_b    = r_b[7:4];
                w_rci  = ADD_RCO;
                w_next = S_DONE;
            end
            S_DONE: begin
`ifdef SUMADOR8_CLR_EN
                w_enb  = 1'b1;
                w_modo = MODO_CLR;
`else
                w_enb  = 1'b0;
                w_modo = MODO_HOLD;
`endif
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant bookkeeping and operand capture; only the latched copy is used later
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last <= 1'b1;
            r_gnt  <= 1'b0;
            r_op   <= 1'b0;
            r_a    <= 8'd0;
            r_b    <= 8'd0;
        end else if (w_grant) begin
            r_last <= w_gnt_idx;
            r_gnt  <= w_gnt_idx;
            r_op   <= w_gnt_idx ? OP1 : OP0;
            r_a    <= w_gnt_idx ? A1  : A0;
            r_b    <= w_gnt_idx ? B1  : B0;
        end
    end

    // Low result nibble is on ADD_Q throughout HI
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lo <= 4'd0;
        end else if (r_state == S_HI) begin
            r_lo <= ADD_Q;
        end
    end

    // Result, carry/borrow and the one-cycle acknowledge to the granted client
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_res  <= 8'd0;
            r_co   <= 1'b0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (r_state == S_DONE) begin
                r_res  <= {ADD_Q, r_lo};
                r_co   <= ADD_RCO;
                r_ack0 <= ~r_gnt;
                r_ack1 <= r_gnt;
            end
        end
    end

    assign ACK0     = r_ack0;
    assign ACK1     = r_ack1;
    assign RES      = r_res;
    assign CO       = r_co;
    assign BUSY     = (r_state != S_IDLE);
    assign ADD_ENB  = w_enb;
    assign ADD_MODO = w_modo;
    assign ADD_A    = w_a;
    assign ADD_B    = w_b;
    assign ADD_RCI  = w_rci;

endmodule

// File: doc/sumador8_ctrl.md
# sumador8_ctrl

Sequencer and two-requester arbiter for the shared 4-bit registered adder `sumador4`. Accepts 8-bit add/subtract requests from two clients, grants one at a time in round-robin order, runs each operation as two nibble passes through `sumador4` (low nibble, then high nibble with carry/borrow chained through `RCI`), and returns an 8-bit result plus carry/borrow with a one-cycle acknowledge. Sits between the client logic and the single `sumador4` instance.

## Interface
- No parameters; widths fixed (8-bit operands, 4-bit adder).
- `CLK`  in  1  rising-edge clock, shared with `sumador4`
- `RST`  in  1  asynchronous, active-high reset
- `REQ0`, `REQ1`  in  1  request; held high until matching `ACK`
- `OP0`, `OP1`  in  1  0 = add, 1 = subtract
- `A0`, `B0`, `A1`, `B1`  in  8  operands per requester
- `ACK0`, `ACK1`  out  1  one-cycle completion pulse, registered
- `RES`  out  8  result, valid while `ACK*` high, held until next completion
- `CO`  out  1  carry (add) / borrow (sub) out of bit 7, same timing as `RES`
- `BUSY`  out  1  high while an operation is in flight
- `ADD_ENB`  out  1  to `sumador4.ENB`
- `ADD_MODO`  out  2  to `sumador4.MODO`
- `ADD_A`, `ADD_B`  out  4  to `sumador4.A` / `.B`
- `ADD_RCI`  out  1  to `sumador4.RCI`
- `ADD_Q`  in  4  from `sumador4.Q`
- `ADD_RCO`  in  1  from `sumador4.RCO`

## Operation
- `sumador4` behaviour: `MODO` 01 → `Q<=A+B+RCI`, `RCO` = carry; `MODO` 10 → `Q<=A-B-RCI`, `RCO` = borrow; `MODO` 00 → hold; `MODO` 11 → `Q`, `RCO` cleared; `ENB`=0 → hold. Results appear after the rising edge that samples the inputs.
- FSM states: IDLE, LO, HI, DONE.
- IDLE: `ADD_ENB`=0, `ADD_MODO`=00, `ADD_A`=`ADD_B`=0, `ADD_RCI`=0. A requester is eligible if its `REQ` is high and its `ACK` is low this cycle. If one is eligible, grant it; if both are eligible, grant the one not equal to `LAST`. On grant, latch operands and op, set `LAST` to the granted index, then go to LO.
- LO: `ADD_ENB`=1, `ADD_MODO`=01 (add) or 10 (sub), `ADD_A`/`ADD_B` = latched bits [3:0], `ADD_RCI`=0. Then go to HI.
- HI: capture `ADD_Q` as the low result nibble. Drive the same mode, latched bits [7:4], and `ADD_RCI`=`ADD_RCO`. Then go to DONE.
- DONE: register `RES`={`ADD_Q`, low nibble} and `CO`=`ADD_RCO`. Pulse the granted `ACK` for the next cycle. Drive `ADD_ENB`=0, `ADD_MODO`=00 (see Configuration). Then go to IDLE.
- `BUSY` is high in LO, HI and DONE.
- Arithmetic is modulo 256. Subtract returns A−B in two's complement, with `CO`=1 when A<B unsigned.
- Operands may change after the grant edge; only the latched copy is used.

## Timing
- Reset values: state IDLE, `LAST`=1 (so `REQ0` wins the first tie), `ACK0`=`ACK1`=0, `RES`=0, `CO`=0, `BUSY`=0, all `ADD_*` outputs 0.
- Latency: grant at edge k; `ACK` and `RES` are valid in the cycle after edge k+3.
- Throughput: one operation per 4 cycles. A requester holding `REQ` through its `ACK` cycle is re-eligible at the following IDLE edge.
- Simultaneous requests: strict alternation while both are held.
- `RST` mid-operation (LO, HI or DONE): immediate return to reset values. The in-flight operation is dropped with no `ACK`; the requester must keep `REQ` high, and it is re-served after reset.
- A request arriving while `BUSY` waits. No request is lost while `REQ` stays high.

## Configuration
- `SUMADOR8_CLR_EN` defined: DONE drives `ADD_ENB`=1, `ADD_MODO`=11, so `sumador4` `Q`/`RCO` are 0 from the cycle after DONE. This does not change latency.
- Not defined: DONE drives `ADD_ENB`=0, `ADD_MODO`=00, and the adder retains the high nibble and carry of the last operation.

## Test plan
- Reset: assert `RST` with random inputs → all outputs 0; `REQ0`=`REQ1`=1 on release → `REQ0` granted first.
- `REQ0`, add 0x0F+0x01 → `ADD_RCI`=1 in HI; `ACK0` three edges after grant; `RES`=0x10, `CO`=0. Add 0xFF+0x01 → `RES`=0x00, `CO`=1.
- `REQ1`, subtract 0x05−0x09 → `RES`=0xFC, `CO`=1. Subtract 0x20−0x01 → `RES`=0x1F, `CO`=0 (borrow chained through `ADD_RCI`).
- Both `REQ` held for four operations → grants 0,1,0,1; each `ACK` is exactly one cycle; `BUSY` is low only in the IDLE cycle between operations.
- `RST` pulsed while in HI → no `ACK`, outputs at reset values; with `REQ1` still high → a correct `ACK1` 4 cycles after release.
- With `SUMADOR8_CLR_EN`: `ADD_MODO`=11 in DONE and `ADD_Q`=0 afterward. Without it: `ADD_MODO`=00 and `ADD_Q` keeps the high nibble.
